line_window_buffer: RTL and testbench

- Parametrised successor to the single-line pixel buffer: a circular pixel store with full/empty flow control.
- Presents a horizontal window of TAPS adjacent pixels (oldest pixel in MSBs) to the downstream filter stage.
- Counts windows per image line; at line end it discards the trailing TAPS-1 pixels, so windows never straddle two lines.
- Sits between the greyscale pixel source and the convolution/filter datapath.

---
 rtl/line_window_buffer.sv | 119 +++++++++++
 tb/tb_line_window_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Circular pixel store presenting a TAPS-wide horizontal window; drops the trailing TAPS-1 pixels at each line end.
// Optional sticky overflow/underrun flags (err, err_code) when LWB_ERR_FLAG_EN is defined.
module line_window_buffer #(
    parameter int PIXEL_W    = 8,
    parameter int TAPS       = 3,
    parameter int LINE_WIDTH = 512,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_pixel,
    input  logic [PIXEL_W-1:0]      pixel_in,
    output logic                    ready_in,
    input  logic                    read_pixel,
    output logic                    out_valid,
    output logic [TAPS*PIXEL_W-1:0] pixel_out,
    output logic                    eol,
    output logic [ADDR_W:0]         count,
    output logic                    full,
    output logic                    empty
`ifdef LWB_ERR_FLAG_EN
    ,
    output logic                    err,
    output logic [1:0]              err_code
`endif
);

    localparam int WIN_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   TAPS_C   = (ADDR_W+1)'(TAPS);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] TAPS_A   = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [WIN_W-1:0]  LAST_WIN = WIN_W'(LINE_WIDTH - TAPS);
    localparam logic [WIN_W-1:0]  ONE_W    = WIN_W'(1);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [WIN_W-1:0]   win_idx;
    logic [ADDR_W:0]    count_next;
    logic               wr_acc;
    logic               rd_acc;
    logic               line_end;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign ready_in  = !full;
    assign out_valid = (count >= TAPS_C);
    assign wr_acc    = valid_pixel && !full;
    assign rd_acc    = read_pixel && out_valid;
    assign line_end  = (win_idx == LAST_WIN);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (wr_acc)
            count_next = count_next + ONE_C;
        if (rd_acc)
            count_next = count_next - (line_end ? TAPS_C : ONE_C);
    end

    // Window read wraps naturally because DEPTH is a power of two addressed by ADDR_W bits.
    always_comb begin
        pixel_out = '0;
        for (int k = 0; k < TAPS; k++)
            pixel_out[(TAPS-1-k)*PIXEL_W +: PIXEL_W] = mem[rd_ptr + ADDR_W'(k)];
    end

    // NOTE: the pixel store has no reset; stale contents are unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= pixel_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            win_idx <= '0;
            eol     <= 1'b0;
        end else begin
            count <= count_next;
            eol   <= rd_acc && line_end;
            if (wr_acc)
                wr_ptr <= wr_ptr + ONE_A;
            if (rd_acc) begin
                if (line_end) begin
                    rd_ptr  <= rd_ptr + TAPS_A;
                    win_idx <= '0;
                end else begin
                    rd_ptr  <= rd_ptr + ONE_A;
                    win_idx <= win_idx + ONE_W;
                end
            end
        end
    end

`ifdef LWB_ERR_FLAG_EN
    // bit0: write attempted while full, bit1: read requested with no valid window.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_code <= '0;
        end else begin
            if (valid_pixel && full)
                err_code[0] <= 1'b1;
            if (read_pixel && !out_valid)
                err_code[1] <= 1'b1;
        end
    end

    assign err = |err_code;
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: table-driven vectors plus hand sequences for full, wrap, concurrent access and reset.
module tb_line_window_buffer;

    localparam int PW    = 8;
    localparam int TAPS  = 3;
    localparam int LW    = 8;
    localparam int LW_W  = 5;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (LINE_WIDTH = 8)
    logic            rst = 1'b1;
    logic            valid_pixel = 1'b0;
    logic [PW-1:0]   pixel_in = '0;
    logic            read_pixel = 1'b0;
    logic            ready_in, out_valid, eol, full, empty;
    logic [TAPS*PW-1:0] pixel_out;
    logic [AW:0]     count;
`ifdef LWB_ERR_FLAG_EN
    logic            err;
    logic [1:0]      err_code;
`endif

    // wrap instance (LINE_WIDTH = 5, so a line base can land on the last entry)
    logic            w_rst = 1'b1;
    logic            w_valid_pixel = 1'b0;
    logic [PW-1:0]   w_pixel_in = '0;
    logic            w_read_pixel = 1'b0;
    logic            w_ready_in, w_out_valid, w_eol, w_full, w_empty;
    logic [TAPS*PW-1:0] w_pixel_out;
    logic [AW:0]     w_count;
`ifdef LWB_ERR_FLAG_EN
    logic            w_err;
    logic [1:0]      w_err_code;
`endif

    line_window_buffer #(
        .PIXEL_W(PW), .TAPS(TAPS), .LINE_WIDTH(LW), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .valid_pixel(valid_pixel), .pixel_in(pixel_in),
        .ready_in(ready_in), .read_pixel(read_pixel), .out_valid(out_valid),
        .pixel_out(pixel_out), .eol(eol), .count(count), .full(full), .empty(empty)
`ifdef LWB_ERR_FLAG_EN
        , .err(err), .err_code(err_code)
`endif
    );

    line_window_buffer #(
        .PIXEL_W(PW), .TAPS(TAPS), .LINE_WIDTH(LW_W), .DEPTH(DEPTH), .ADDR_W(AW)
    ) dut_w (
        .clk(clk), .rst(w_rst), .valid_pixel(w_valid_pixel), .pixel_in(w_pixel_in),
        .ready_in(w_ready_in), .read_pixel(w_read_pixel), .out_valid(w_out_valid),
        .pixel_out(w_pixel_out), .eol(w_eol), .count(w_count), .full(w_full), .empty(w_empty)
`ifdef LWB_ERR_FLAG_EN
        , .err(w_err), .err_code(w_err_code)
`endif
    );

    typedef struct {
        logic        rst;
        logic        vp;
        logic [7:0]  pix;
        logic        rd;
        logic        exp_ov;
        logic [23:0] exp_win;
        logic [4:0]  exp_count;
        logic        exp_eol;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic vp, input logic [7:0] pix, input logic rd,
                                input logic ov, input logic [23:0] win, input logic [4:0] cnt,
                                input logic e);
        vec_t v;
        v.rst = r; v.vp = vp; v.pix = pix; v.rd = rd;
        v.exp_ov = ov; v.exp_win = win; v.exp_count = cnt; v.exp_eol = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock on the main instance; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic vp, input logic [7:0] pix, input logic rdp);
        rst = r; valid_pixel = vp; pixel_in = pix; read_pixel = rdp;
        @(posedge clk);
        #1;
        rst = 1'b0; valid_pixel = 1'b0; read_pixel = 1'b0;
    endtask

    task automatic w_step(input logic r, input logic vp, input logic [7:0] pix, input logic rdp);
        w_rst = r; w_valid_pixel = vp; w_pixel_in = pix; w_read_pixel = rdp;
        @(posedge clk);
        #1;
        w_rst = 1'b0; w_valid_pixel = 1'b0; w_read_pixel = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [23:0] exp_win;
        int          exp_cnt;

        // ---- tests 1 and 2 as a vector table ----
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 24'h0, 5'd0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0, 24'h0, 5'd1, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 24'h0, 5'd2, 0));
        vecs.push_back(mk(0, 1, 8'h12, 0, 1, 24'h101112, 5'd3, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 24'h0, 5'd0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 24'h0, 5'd1, 0));
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 24'h0, 5'd2, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 24'h000102, 5'd3, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 1, 24'h000102, 5'd4, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 1, 24'h000102, 5'd5, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 1, 24'h000102, 5'd6, 0));
        vecs.push_back(mk(0, 1, 8'h06, 0, 1, 24'h000102, 5'd7, 0));
        vecs.push_back(mk(0, 1, 8'h07, 0, 1, 24'h000102, 5'd8, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 24'h010203, 5'd7, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 24'h020304, 5'd6, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 24'h030405, 5'd5, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 24'h040506, 5'd4, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 24'h050607, 5'd3, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 24'h0, 5'd0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 24'h0, 5'd0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 24'h0, 5'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vp, vecs[i].pix, vecs[i].rd);
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d eol", i), 32'(eol), 32'(vecs[i].exp_eol));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_count == 5'd0));
            check($sformatf("vec%0d ready_in", i), 32'(ready_in), 32'(vecs[i].exp_count != 5'd16));
            if (vecs[i].exp_ov)
                check($sformatf("vec%0d pixel_out", i), 32'(pixel_out), 32'(vecs[i].exp_win));
        end

        // ---- test 3: fill to DEPTH, then a dropped write ----
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(8'h20 + i), 0);
            if (i == 14) begin
                check("fill15 full", 32'(full), 32'd0);
                check("fill15 count", 32'(count), 32'd15);
            end
        end
        check("fill16 full", 32'(full), 32'd1);
        check("fill16 ready_in", 32'(ready_in), 32'd0);
        check("fill16 count", 32'(count), 32'd16);
        step(0, 1, 8'hEE, 0);
        check("drop count", 32'(count), 32'd16);
        check("drop pixel_out", 32'(pixel_out), 32'h202122);
`ifdef LWB_ERR_FLAG_EN
        check("drop err", 32'(err), 32'd1);
        check("drop err_code", 32'(err_code), 32'b01);
`endif

        // ---- test 4: window straddling the end of the store (wrap instance) ----
        w_step(1, 0, 8'h00, 0);
        for (int i = 0; i < 15; i++)
            w_step(0, 1, 8'(8'h40 + i), 0);
        check("wrap prefill count", 32'(w_count), 32'd15);
        exp_cnt = 15;
        for (int j = 0; j < 9; j++) begin
            w_step(0, 0, 8'h00, 1);
            exp_cnt -= ((j % 3) == 2) ? 3 : 1;
            check($sformatf("wrap read%0d count", j), 32'(w_count), 32'(exp_cnt));
            check($sformatf("wrap read%0d eol", j), 32'(w_eol), 32'((j % 3) == 2));
        end
        w_step(0, 1, 8'hAA, 0);
        w_step(0, 1, 8'hBB, 0);
        w_step(0, 1, 8'hCC, 0);
        check("wrap out_valid", 32'(w_out_valid), 32'd1);
        check("wrap pixel_out", 32'(w_pixel_out), 32'hAABBCC);

        // ---- test 5: simultaneous write and read, mid-line then at line end ----
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 8'(8'h30 + i), 0);
        check("sim pre count", 32'(count), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 8'(8'h34 + k), 1);
            b = 8'(8'h30 + k);
            exp_win = {b, b + 8'd1, b + 8'd2};
            check($sformatf("sim%0d count", k), 32'(count), 32'd5);
            check($sformatf("sim%0d pixel_out", k), 32'(pixel_out), 32'(exp_win));
            check($sformatf("sim%0d eol", k), 32'(eol), 32'd0);
        end
        step(0, 1, 8'h3A, 1);
        check("sim eol-line count", 32'(count), 32'd3);
        check("sim eol-line eol", 32'(eol), 32'd1);
        check("sim eol-line pixel_out", 32'(pixel_out), 32'h38393A);
        step(0, 0, 8'h00, 0);
        check("sim after eol", 32'(eol), 32'd0);

        // ---- test 6: reset mid-line ----
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        check("underrun count", 32'(count), 32'd0);
`ifdef LWB_ERR_FLAG_EN
        check("underrun err_code", 32'(err_code), 32'b10);
`endif
        for (int i = 0; i < 8; i++)
            step(0, 1, 8'(8'h60 + i), 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        check("midline count", 32'(count), 32'd6);
        check("midline pixel_out", 32'(pixel_out), 32'h626364);
        step(1, 0, 8'h00, 0);
        check("rst count", 32'(count), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst eol", 32'(eol), 32'd0);
`ifdef LWB_ERR_FLAG_EN
        check("rst err", 32'(err), 32'd0);
`endif
        step(0, 1, 8'h55, 0);
        step(0, 1, 8'h66, 0);
        step(0, 1, 8'h77, 0);
        check("post-rst out_valid", 32'(out_valid), 32'd1);
        check("post-rst pixel_out", 32'(pixel_out), 32'h556677);
        check("post-rst count", 32'(count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
